// File: rtl/alu.sv
// Execute-stage integer ALU: combinational result plus a registered HI/LO pair.
// Define ALU_DIV_EN to build the single-cycle divider for DIV/DIVU (opcodes 19/20).
module alu (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [5:0]  ALU_control,
  input  logic [4:0]  shiftAmount,
  input  logic [31:0] HI_IN,
  input  logic [31:0] LO_IN,
  output logic [31:0] aluResult,
  output logic [31:0] HI_OUT,
  output logic [31:0] LO_OUT
);

  localparam logic [5:0] OP_ADD   = 6'd0;
  localparam logic [5:0] OP_ADDU  = 6'd1;
  localparam logic [5:0] OP_SUB   = 6'd2;
  localparam logic [5:0] OP_SUBU  = 6'd3;
  localparam logic [5:0] OP_AND   = 6'd4;
  localparam logic [5:0] OP_OR    = 6'd5;
  localparam logic [5:0] OP_XOR   = 6'd6;
  localparam logic [5:0] OP_NOR   = 6'd7;
  localparam logic [5:0] OP_SLT   = 6'd8;
  localparam logic [5:0] OP_SLTU  = 6'd9;
  localparam logic [5:0] OP_SLL   = 6'd10;
  localparam logic [5:0] OP_SRL   = 6'd11;
  localparam logic [5:0] OP_SRA   = 6'd12;
  localparam logic [5:0] OP_SLLV  = 6'd13;
  localparam logic [5:0] OP_SRLV  = 6'd14;
  localparam logic [5:0] OP_SRAV  = 6'd15;
  localparam logic [5:0] OP_LUI   = 6'd16;
  localparam logic [5:0] OP_MULT  = 6'd17;
  localparam logic [5:0] OP_MULTU = 6'd18;
`ifdef ALU_DIV_EN
  localparam logic [5:0] OP_DIV   = 6'd19;
  localparam logic [5:0] OP_DIVU  = 6'd20;
`endif
  localparam logic [5:0] OP_MFHI  = 6'd21;
  localparam logic [5:0] OP_MFLO  = 6'd22;
  localparam logic [5:0] OP_MTHI  = 6'd23;
  localparam logic [5:0] OP_MTLO  = 6'd24;
  localparam logic [5:0] OP_PASSA = 6'd25;
  localparam logic [5:0] OP_PASSB = 6'd26;

  logic [31:0] hi_next;
  logic [31:0] lo_next;
  logic [63:0] prod_signed;
  logic [63:0] prod_unsigned;

  assign prod_signed   = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_unsigned = {32'b0, A} * {32'b0, B};

`ifdef ALU_DIV_EN
  // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 naturally.
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] mag_quot;
  logic [31:0] mag_rem;
  logic [31:0] sdiv_quot;
  logic [31:0] sdiv_rem;
  logic [31:0] udiv_quot;
  logic [31:0] udiv_rem;
  logic        b_zero;

  assign b_zero    = (B == 32'd0);
  assign abs_a     = A[31] ? (32'd0 - A) : A;
  assign abs_b     = B[31] ? (32'd0 - B) : B;
  assign mag_quot  = b_zero ? 32'd0 : abs_a / abs_b;
  assign mag_rem   = b_zero ? 32'd0 : abs_a % abs_b;
  assign sdiv_quot = (A[31] ^ B[31]) ? (32'd0 - mag_quot) : mag_quot;
  assign sdiv_rem  = A[31] ? (32'd0 - mag_rem) : mag_rem;
  assign udiv_quot = b_zero ? 32'd0 : A / B;
  assign udiv_rem  = b_zero ? 32'd0 : A % B;
`endif

  always_comb begin
    aluResult = 32'd0;
    hi_next   = HI_IN;
    lo_next   = LO_IN;
    case (ALU_control)
      OP_ADD, OP_ADDU: aluResult = A + B;
      OP_SUB, OP_SUBU: aluResult = A - B;
      OP_AND:          aluResult = A & B;
      OP_OR:           aluResult = A | B;
      OP_XOR:          aluResult = A ^ B;
      OP_NOR:          aluResult = ~(A | B);
      OP_SLT:          aluResult = {31'd0, ($signed(A) < $signed(B))};
      OP_SLTU:         aluResult = {31'd0, (A < B)};
      OP_SLL:          aluResult = B << shiftAmount;
      OP_SRL:          aluResult = B >> shiftAmount;
      OP_SRA:          aluResult = $signed(B) >>> shiftAmount;
      OP_SLLV:         aluResult = B << A[4:0];
      OP_SRLV:         aluResult = B >> A[4:0];
      OP_SRAV:         aluResult = $signed(B) >>> A[4:0];
      OP_LUI:          aluResult = {B[15:0], 16'h0000};
      OP_MULT:         {hi_next, lo_next} = prod_signed;
      OP_MULTU:        {hi_next, lo_next} = prod_unsigned;
`ifdef ALU_DIV_EN
      OP_DIV: begin
        if (b_zero) begin
          lo_next = 32'hFFFF_FFFF;
          hi_next = A;
        end else begin
          lo_next = sdiv_quot;
          hi_next = sdiv_rem;
        end
      end
      OP_DIVU: begin
        if (b_zero) begin
          lo_next = 32'hFFFF_FFFF;
          hi_next = A;
        end else begin
          lo_next = udiv_quot;
          hi_next = udiv_rem;
        end
      end
`endif
      OP_MFHI:         aluResult = HI_IN;
      OP_MFLO:         aluResult = LO_IN;
      OP_MTHI:         hi_next = A;
      OP_MTLO:         lo_next = A;
      OP_PASSA:        aluResult = A;
      OP_PASSB:        aluResult = B;
      default:         aluResult = 32'd0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      HI_OUT <= 32'd0;
      LO_OUT <= 32'd0;
    end else begin
      HI_OUT <= hi_next;
      LO_OUT <= lo_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed plan vectors, then random vectors
// against an arithmetic reference model.
module tb_alu;
  logic        CLK;
  logic        RESET;
  logic [31:0] A;
  logic [31:0] B;
  logic [5:0]  ALU_control;
  logic [4:0]  shiftAmount;
  logic [31:0] HI_IN;
  logic [31:0] LO_IN;
  logic [31:0] aluResult;
  logic [31:0] HI_OUT;
  logic [31:0] LO_OUT;

  int n_vec = 0;
  int n_err = 0;

  alu dut (
    .CLK(CLK), .RESET(RESET), .A(A), .B(B), .ALU_control(ALU_control),
    .shiftAmount(shiftAmount), .HI_IN(HI_IN), .LO_IN(LO_IN),
    .aluResult(aluResult), .HI_OUT(HI_OUT), .LO_OUT(LO_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: MIPS semantics computed with plain integer arithmetic.
  function automatic void ref_alu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh, input logic [31:0] hi_in, input logic [31:0] lo_in,
                                  output logic [31:0] res, output logic [31:0] hi, output logic [31:0] lo);
    int          ia = a;
    int          ib = b;
    longint      la = ia;
    longint      lb = ib;
    longint      sp;
    logic [63:0] up;
    int          vsh = int'(a % 32);
    res = 0; hi = hi_in; lo = lo_in;
    case (op)
      0, 1:  res = a + b;
      2, 3:  res = a - b;
      4:     res = a & b;
      5:     res = a | b;
      6:     res = a ^ b;
      7:     res = ~(a | b);
      8:     res = (ia < ib) ? 1 : 0;
      9:     res = (a < b) ? 1 : 0;
      10:    res = b << sh;
      11:    res = b >> sh;
      12:    res = ib >>> sh;
      13:    res = b << vsh;
      14:    res = b >> vsh;
      15:    res = ib >>> vsh;
      16:    res = b * 32'd65536;
      17: begin sp = la * lb; hi = sp[63:32]; lo = sp[31:0]; end
      18: begin up = 64'(a) * 64'(b); hi = up[63:32]; lo = up[31:0]; end
`ifdef ALU_DIV_EN
      19: begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin sp = la / lb; lo = sp[31:0]; sp = la % lb; hi = sp[31:0]; end
      end
      20: begin
        if (b == 0) begin lo = 32'hFFFF_FFFF; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
`endif
      21:    res = hi_in;
      22:    res = lo_in;
      23:    hi = a;
      24:    lo = a;
      25:    res = a;
      26:    res = b;
      default: res = 0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, check result combinationally, then HI/LO after the rising edge.
  task automatic apply(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] hi_in, input logic [31:0] lo_in);
    logic [31:0] er, eh, el;
    @(negedge CLK);
    ALU_control = op; A = a; B = b; shiftAmount = sh; HI_IN = hi_in; LO_IN = lo_in;
    ref_alu(op, a, b, sh, hi_in, lo_in, er, eh, el);
    #1;
    check($sformatf("res op%0d a=%h b=%h", op, a, b), aluResult, er);
    @(posedge CLK);
    #1;
    check($sformatf("hi op%0d a=%h b=%h", op, a, b), HI_OUT, eh);
    check($sformatf("lo op%0d a=%h b=%h", op, a, b), LO_OUT, el);
    $display("op=%0d a=%h b=%h sh=%0d res=%h hi=%h lo=%h", op, a, b, sh, aluResult, HI_OUT, LO_OUT);
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] ra, rb;
    RESET = 1'b1; A = 0; B = 0; ALU_control = 6'd63; shiftAmount = 0;
    HI_IN = 32'h1234; LO_IN = 32'h1234;

    // Reset: prime outputs with pass-through, then drop RESET mid-cycle.
    repeat (2) @(posedge CLK);
    #1;
    check("prime_hi", HI_OUT, 32'h1234);
    check("prime_lo", LO_OUT, 32'h1234);
    #2 RESET = 1'b0;
    #1;
    check("rst_hi", HI_OUT, 32'h0);
    check("rst_lo", LO_OUT, 32'h0);
    @(negedge CLK);
    #1;
    check("rst_hold_hi", HI_OUT, 32'h0);
    RESET = 1'b1;
    apply(6'd0, 32'd0, 32'd0, 5'd0, 32'h1234, 32'h1234);
    check("rel_hi", HI_OUT, 32'h1234);
    check("rel_lo", LO_OUT, 32'h1234);

    // Directed plan vectors with literal expectations.
    apply(6'd0, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 32'd0);
    check("add_wrap", aluResult, 32'h0);
    apply(6'd2, 32'd0, 32'd1, 5'd0, 32'd0, 32'd0);
    check("sub_wrap", aluResult, 32'hFFFF_FFFF);
    apply(6'd8, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 32'd0);
    check("slt", aluResult, 32'd1);
    apply(6'd9, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 32'd0);
    check("sltu", aluResult, 32'd0);
    apply(6'd12, 32'd0, 32'h8000_0000, 5'd4, 32'd0, 32'd0);
    check("sra", aluResult, 32'hF800_0000);
    apply(6'd14, 32'h24, 32'h8000_0000, 5'd0, 32'd0, 32'd0);
    check("srlv", aluResult, 32'h0800_0000);
    apply(6'd17, 32'hFFFF_FFFE, 32'd3, 5'd0, 32'd0, 32'd0);
    check("mult_hi", HI_OUT, 32'hFFFF_FFFF);
    check("mult_lo", LO_OUT, 32'hFFFF_FFFA);
    apply(6'd18, 32'hFFFF_FFFE, 32'd3, 5'd0, 32'd0, 32'd0);
    check("multu_hi", HI_OUT, 32'd2);
    check("multu_lo", LO_OUT, 32'hFFFF_FFFA);
`ifdef ALU_DIV_EN
    apply(6'd19, 32'hFFFF_FFF9, 32'd2, 5'd0, 32'd0, 32'd0);
    check("div_lo", LO_OUT, 32'hFFFF_FFFD);
    check("div_hi", HI_OUT, 32'hFFFF_FFFF);
    apply(6'd20, 32'd7, 32'd0, 5'd0, 32'd0, 32'd0);
    check("divu0_lo", LO_OUT, 32'hFFFF_FFFF);
    check("divu0_hi", HI_OUT, 32'd7);
    apply(6'd19, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'd0, 32'd0);
    check("div_ovf_lo", LO_OUT, 32'h8000_0000);
    check("div_ovf_hi", HI_OUT, 32'h0);
`else
    apply(6'd19, 32'hFFFF_FFF9, 32'd2, 5'd0, 32'h55, 32'h66);
    check("nodiv_hi", HI_OUT, 32'h55);
    check("nodiv_lo", LO_OUT, 32'h66);
`endif
    apply(6'd23, 32'hCAFE_0000, 32'd0, 5'd0, 32'd0, 32'd5);
    check("mthi_hi", HI_OUT, 32'hCAFE_0000);
    check("mthi_lo", LO_OUT, 32'd5);
    apply(6'd22, 32'd0, 32'd0, 5'd0, 32'hCAFE_0000, 32'd5);
    check("mflo", aluResult, 32'd5);

    // Random vectors, including unsupported codes and division corner operands.
    for (int i = 0; i < 400; i++) begin
      op = 6'($urandom_range(0, 31));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      apply(op, ra, rb, 5'($urandom), $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu.md
# alu

Integer ALU for the MIPS out-of-order pipeline's execute stage. It computes a 32-bit combinational result from two operands, a 6-bit operation code and a shift amount. It also maintains the multiply/divide HI/LO pair through registered outputs that the parent stage feeds back on its HI_IN/LO_IN inputs. The parent drives CLK with its inverted pipeline clock, so HI/LO updates settle half a pipeline cycle before the parent samples them.

## Interface
- No parameters.
- CLK  input  1  clock; all registered state updates on its rising edge.
- RESET  input  1  asynchronous, active-low reset.
- A  input  32  operand A (rs).
- B  input  32  operand B (rt or immediate).
- ALU_control  input  6  operation code (see Operation).
- shiftAmount  input  5  immediate shift amount for SLL/SRL/SRA.
- HI_IN  input  32  current architectural HI.
- LO_IN  input  32  current architectural LO.
- aluResult  output  32  combinational result.
- HI_OUT  output  32  registered next-HI value.
- LO_OUT  output  32  registered next-LO value.

## Operation
Decimal opcodes; aluResult is combinational.
- 0 ADD and 1 ADDU: A+B, modulo 2^32, no overflow trap.
- 2 SUB and 3 SUBU: A−B, modulo 2^32.
- 4 AND, 5 OR, 6 XOR, 7 NOR: bitwise.
- 8 SLT: 1 if signed A<B, else 0. 9 SLTU: unsigned compare.
- 10 SLL, 11 SRL, 12 SRA: B shifted by shiftAmount. SRA sign-fills.
- 13 SLLV, 14 SRLV, 15 SRAV: B shifted by A[4:0]. A[31:5] is ignored.
- 16 LUI: {B[15:0],16'h0}.
- 17 MULT (signed) and 18 MULTU: 64-bit product, {HI,LO} = product. aluResult = 0.
- 19 DIV (signed) and 20 DIVU: LO = quotient, HI = remainder.
  - Signed division truncates toward zero; remainder takes the sign of A.
  - Divide by zero: LO = 32'hFFFFFFFF, HI = A.
  - Signed 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0.
  - aluResult = 0.
- 21 MFHI: aluResult = HI_IN. 22 MFLO: aluResult = LO_IN.
- 23 MTHI: HI ← A, LO unchanged. 24 MTLO: LO ← A, HI unchanged. aluResult = 0.
- 25 PASSA: aluResult = A. 26 PASSB: aluResult = B.
- Any other code: aluResult = 0, HI/LO pass through.
- For every opcode that does not write HI/LO, HI_OUT/LO_OUT take HI_IN/LO_IN at the edge. The outputs therefore always track the architectural value.
- All arithmetic is 32-bit two's complement. The multiply is a full 64-bit result; there is no saturation.

## Timing
- aluResult: zero-latency combinational from A, B, ALU_control, shiftAmount, HI_IN, LO_IN.
- HI_OUT/LO_OUT: registered, one CLK rising edge of latency. The value computed from the inputs present at the edge is visible after that edge.
- Multiply and divide complete in a single cycle; there is no busy/stall handshake.
- RESET low, asynchronously, at any time including mid-operation: HI_OUT = LO_OUT = 0 immediately. aluResult is unaffected because it is combinational.
- After RESET deasserts, the first rising edge resumes normal updates.
- Back-to-back MULT then MFHI: MFHI reads HI_IN, i.e. whatever the parent has fed back. The ALU does no internal forwarding.

## Configuration
- ALU_DIV_EN defined: opcodes 19/20 are implemented as specified.
- ALU_DIV_EN undefined: no divider is built. Opcodes 19/20 behave as unsupported codes: aluResult = 0 and HI/LO pass through from HI_IN/LO_IN.

## Test plan
- RESET low with HI_IN = LO_IN = 32'h1234 -> HI_OUT = LO_OUT = 0 without any clock edge. After release and one edge with opcode 0, both outputs = 32'h1234.
- ADD: A = 32'hFFFFFFFF, B = 1 -> aluResult = 0. SUB: A = 0, B = 1 -> 32'hFFFFFFFF. SLT: A = 32'hFFFFFFFF, B = 1 -> 1. SLTU with the same operands -> 0.
- SRA: B = 32'h80000000, shiftAmount = 4 -> 32'hF8000000. SRLV: A = 32'h24, B = 32'h80000000 -> 32'h08000000, since only A[4:0] = 4 is used.
- MULT: A = 32'hFFFFFFFE (−2), B = 3 -> after one edge HI_OUT = 32'hFFFFFFFF, LO_OUT = 32'hFFFFFFFA. MULTU with the same operands -> HI_OUT = 2, LO_OUT = 32'hFFFFFFFA.
- With ALU_DIV_EN:
  - DIV A = −7, B = 2 -> LO_OUT = 32'hFFFFFFFD, HI_OUT = 32'hFFFFFFFF.
  - DIVU A = 7, B = 0 -> LO_OUT = 32'hFFFFFFFF, HI_OUT = 7.
- MTHI: A = 32'hCAFE0000, LO_IN = 5 -> after one edge HI_OUT = 32'hCAFE0000, LO_OUT = 5. MFLO with LO_IN = 5 -> aluResult = 5.
